imm_gen_stage: RTL and testbench

//  Pipelined immediate generator for the RV32I/RV64I decode stage. Accepts a raw

---
 rtl/imm_pkg.sv | 34 +++
 rtl/imm_decode_comb.sv | 87 ++++++++
 rtl/imm_gen_stage.sv | 112 +++++++++++
 tb/tb_imm_gen_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate-format, opcode and skid-state definitions for imm_gen_stage
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational instr -> {imm, fmt, illegal}; IMMGEN_CSR_EN adds CSR zimm
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_shift;
  logic [63:0] imm_w;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRX);

  // Immediates are built at 64 bits and truncated, so one path serves both XLENs.
  always_comb begin
    imm_w   = '0;
    fmt     = IMM_NONE;
    illegal = 1'b1;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        imm_w   = {{52{instr[31]}}, instr[31:20]};
        fmt     = IMM_I;
        illegal = 1'b0;
      end
      OPC_OPIMM: begin
        fmt     = IMM_I;
        illegal = 1'b0;
        if (is_shift) begin
          if (XLEN == 64) imm_w = {58'b0, instr[25:20]};
          else            imm_w = {59'b0, instr[24:20]};
        end else begin
          imm_w = {{52{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          fmt     = IMM_I;
          illegal = 1'b0;
          if (is_shift) imm_w = {59'b0, instr[24:20]};
          else          imm_w = {{52{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        imm_w   = {{52{instr[31]}}, instr[31:25], instr[11:7]};
        fmt     = IMM_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        imm_w   = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt     = IMM_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_w   = {{32{instr[31]}}, instr[31:12], 12'b0};
        fmt     = IMM_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        imm_w   = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt     = IMM_J;
        illegal = 1'b0;
      end
`ifdef IMMGEN_CSR_EN
      OPC_SYSTEM: begin
        if (f3[2]) begin
          imm_w   = {59'b0, instr[19:15]};
          fmt     = IMM_Z;
          illegal = 1'b0;
        end
      end
`else
`endif
      default: ;
    endcase
  end

  assign imm = imm_w[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with 2-entry skid buffer; IMMGEN_CSR_EN enables CSR zimm
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  skid_state_e     state_q, state_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  imm_fmt_e        out_fmt_q, out_fmt_d;
  logic            out_ill_q, out_ill_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  imm_fmt_e        skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;
  logic            push, pop;

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_ill_d  = out_ill_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_ill;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (push && pop) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_ill;
        end else if (push) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_ill_d = dec_ill;
          state_d    = ST_SKID;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (pop) begin
          out_imm_d = skid_imm_q;
          out_fmt_d = skid_fmt_q;
          out_ill_d = skid_ill_q;
          state_d   = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_fmt_q  <= IMM_NONE;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_fmt_q <= IMM_NONE;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign imm     = out_imm_q;
  assign fmt     = out_fmt_q;
  assign illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int total = 0;
  int bad   = 0;

  logic [31:0] instrq[$];

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready),
    .imm(imm32), .fmt(fmt32), .illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .fmt(fmt64), .illegal(ill64)
  );

  function automatic logic [63:0] asr(input logic [63:0] v, input int n);
    logic signed [63:0] sv;
    sv = v;
    return sv >>> n;
  endfunction

  // Reference decode from the ISA field rules, in 64-bit arithmetic.
  function automatic exp_t ref_model(input logic [31:0] ins, input bit x64);
    exp_t        e;
    logic [63:0] s;
    int          op, f3;
    s  = {{32{ins[31]}}, ins};
    op = int'(ins & 32'h7F);
    f3 = int'((ins >> 12) & 32'h7);
    e.imm = 64'd0;
    e.fmt = IMM_NONE;
    e.ill = 1'b1;
    if (op == 'h03 || op == 'h67 || op == 'h13 || (op == 'h1B && x64)) begin
      e.fmt = IMM_I;
      e.ill = 1'b0;
      if ((op == 'h13 || op == 'h1B) && (f3 == 1 || f3 == 5))
        e.imm = (x64 && op == 'h13) ? (s >> 20) % 64 : (s >> 20) % 32;
      else
        e.imm = asr(s, 20);
    end else if (op == 'h23) begin
      e.fmt = IMM_S; e.ill = 1'b0;
      e.imm = (asr(s, 25) << 5) | ((s >> 7) & 64'h1F);
    end else if (op == 'h63) begin
      e.fmt = IMM_B; e.ill = 1'b0;
      e.imm = (asr(s, 31) << 12) | (((s >> 7) & 64'h1) << 11)
            | (((s >> 25) & 64'h3F) << 5) | (((s >> 8) & 64'hF) << 1);
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = IMM_U; e.ill = 1'b0;
      e.imm = asr(s, 12) << 12;
    end else if (op == 'h6F) begin
      e.fmt = IMM_J; e.ill = 1'b0;
      e.imm = (asr(s, 31) << 20) | (((s >> 12) & 64'hFF) << 12)
            | (((s >> 20) & 64'h1) << 11) | (((s >> 21) & 64'h3FF) << 1);
    end
`ifdef IMMGEN_CSR_EN
    else if (op == 'h73 && f3 >= 4) begin
      e.fmt = IMM_Z; e.ill = 1'b0;
      e.imm = (s >> 15) & 64'h1F;
    end
`endif
    if (!x64) e.imm = e.imm & 64'hFFFF_FFFF;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    exp_t e32, e64;
    chk("in_ready32", {63'd0, in_ready32}, {63'd0, instrq.size() < 2});
    chk("in_ready64", {63'd0, in_ready64}, {63'd0, instrq.size() < 2});
    chk("out_valid32", {63'd0, out_valid32}, {63'd0, instrq.size() > 0});
    chk("out_valid64", {63'd0, out_valid64}, {63'd0, instrq.size() > 0});
    if (instrq.size() > 0) begin
      e32 = ref_model(instrq[0], 1'b0);
      e64 = ref_model(instrq[0], 1'b1);
      chk("imm32", {32'd0, imm32}, e32.imm);
      chk("fmt32", {61'd0, fmt32}, {61'd0, e32.fmt});
      chk("ill32", {63'd0, ill32}, {63'd0, e32.ill});
      chk("imm64", imm64, e64.imm);
      chk("fmt64", {61'd0, fmt64}, {61'd0, e64.fmt});
      chk("ill64", {63'd0, ill64}, {63'd0, e64.ill});
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy);
    logic push, pop;
    in_valid  = v;
    instr     = ins;
    out_ready = ordy;
    @(negedge clk);
    check_model();
    push = v && (instrq.size() < 2);
    pop  = ordy && (instrq.size() > 0);
    @(posedge clk);
    #1;
    if (pop)  void'(instrq.pop_front());
    if (push) instrq.push_back(ins);
  endtask

  task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] e32,
                          input logic [63:0] e64, input logic [2:0] f, input logic il);
    in_valid  = 1'b1;
    instr     = ins;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, {63'd0, in_ready32}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 32'h0;
    @(negedge clk);
    chk({tag, "_v32"}, {63'd0, out_valid32}, 64'd1);
    chk({tag, "_imm32"}, {32'd0, imm32}, {32'd0, e32});
    chk({tag, "_fmt32"}, {61'd0, fmt32}, {61'd0, f});
    chk({tag, "_ill32"}, {63'd0, ill32}, {63'd0, il});
    chk({tag, "_imm64"}, imm64, e64);
    chk({tag, "_fmt64"}, {61'd0, fmt64}, {61'd0, f});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h33};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready32}, 64'd1);
    chk("rst_imm", {32'd0, imm32}, 64'd0);
    chk("rst_fmt", {61'd0, fmt32}, {61'd0, IMM_NONE});
    chk("rst_ill", {63'd0, ill64}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("addi",  32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, IMM_I, 1'b0);
    directed("sw",    32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_S, 1'b0);
    directed("beq",   32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, IMM_B, 1'b0);
    directed("lui",   32'h123452B7, 32'h12345000, 64'h00000000_12345000, IMM_U, 1'b0);
    directed("jal",   32'h001000EF, 32'h00000800, 64'h00000000_00000800, IMM_J, 1'b0);
    directed("slli",  32'h00509093, 32'd5, 64'd5, IMM_I, 1'b0);
    directed("srai",  32'h4030D093, 32'd3, 64'd3, IMM_I, 1'b0);
    directed("srai63", 32'h43F0D093, 32'd31, 64'd63, IMM_I, 1'b0);
    directed("illop", 32'h0000007F, 32'd0, 64'd0, IMM_NONE, 1'b1);
`ifdef IMMGEN_CSR_EN
    directed("csrrwi", 32'h0052D073, 32'd5, 64'd5, IMM_Z, 1'b0);
`else
    directed("csrrwi", 32'h0052D073, 32'd0, 64'd0, IMM_NONE, 1'b1);
`endif

    // Back-pressure: A and B fill the buffer, C must wait.
    cycle(1'b1, 32'hFFF00093, 1'b0);
    cycle(1'b1, 32'hFE20AE23, 1'b0);
    cycle(1'b1, 32'h123452B7, 1'b0);
    chk("skid_block", {63'd0, in_ready32}, 64'd0);
    cycle(1'b1, 32'h123452B7, 1'b1);
    cycle(1'b1, 32'h123452B7, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 16; i++) cycle(1'b1, rand_instr(), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 9) < 6));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

    // Asynchronous reset while holding two entries.
    cycle(1'b1, 32'hFE000CE3, 1'b0);
    cycle(1'b1, 32'h001000EF, 1'b0);
    chk("pre_rst_skid", {63'd0, in_ready64}, 64'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid32", {63'd0, out_valid32}, 64'd0);
    chk("arst_out_valid64", {63'd0, out_valid64}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready32}, 64'd1);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_fmt", {61'd0, fmt32}, {61'd0, IMM_NONE});
    instrq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), rand_instr(), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
